// File: rtl/sensor_sample_feeder.sv
// sensor_sample_feeder: buffers sensor samples in a FIFO and issues them to the
// anomaly detector as single-cycle pulses separated by a fixed idle gap.
module sensor_sample_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           sensor_data,
    input  logic                            sensor_valid,
    output logic                            sensor_ready,
    input  logic                            enable,
    input  logic                            overflow_clr,
    output logic [DATA_WIDTH-1:0]           data_input,
    output logic                            data_valid,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [15:0]                     sample_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, GAP} state_t;

    state_t                state, state_nxt;
    logic [7:0]            gap_cnt, gap_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop;

    // Readiness comes from the registered count, so a full FIFO refuses even on a pop edge
    assign sensor_ready = fifo_count != CW'(FIFO_DEPTH);
    assign push         = sensor_valid && sensor_ready;
    assign pop          = state == IDLE && enable && fifo_count != '0;

    always_comb begin
        state_nxt = (state == IDLE) ? ((pop && GAP_CYCLES != 0) ? GAP : IDLE)
                                    : ((gap_cnt == 8'd1) ? IDLE : GAP);
        gap_nxt   = (state == IDLE) ? 8'(GAP_CYCLES) : gap_cnt - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sensor_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            data_input   <= '0;
            data_valid   <= 1'b0;
            overflow     <= 1'b0;
            sample_count <= '0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            data_valid <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                data_input   <= mem[rd_ptr];
                sample_count <= sample_count + 16'd1;
            end
            // A drop on the same edge as a clear keeps the flag set
            overflow <= (sensor_valid && !sensor_ready) || (overflow && !overflow_clr);
        end
    end
endmodule

// File: tb/tb_sensor_sample_feeder.sv
// tb_sensor_sample_feeder: runs a G=3 and a G=0 feeder side by side against a
// queue-based reference model, plus directed scenarios with literal expectations.
module tb_sensor_sample_feeder;
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       sensor_data = '0;
    logic             sensor_valid = 1'b0;
    logic             enable = 1'b1;
    logic             overflow_clr = 1'b0;
    logic [1:0]       rdy, dv, ov;
    logic [1:0][7:0]  di;
    logic [1:0][3:0]  fc;
    logic [1:0][15:0] sc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sensor_sample_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .GAP_CYCLES(3)) u_g3 (
        .clk(clk), .reset(reset), .sensor_data(sensor_data), .sensor_valid(sensor_valid),
        .sensor_ready(rdy[0]), .enable(enable), .overflow_clr(overflow_clr),
        .data_input(di[0]), .data_valid(dv[0]), .fifo_count(fc[0]),
        .overflow(ov[0]), .sample_count(sc[0]));

    sensor_sample_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .GAP_CYCLES(0)) u_g0 (
        .clk(clk), .reset(reset), .sensor_data(sensor_data), .sensor_valid(sensor_valid),
        .sensor_ready(rdy[1]), .enable(enable), .overflow_clr(overflow_clr),
        .data_input(di[1]), .data_valid(dv[1]), .fifo_count(fc[1]),
        .overflow(ov[1]), .sample_count(sc[1]));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded sample queue per instance plus a count of idle cycles still owed
    logic [7:0]  mq [2][1024];
    int          mh [2];
    int          mt [2];
    int          gl [2];
    logic [7:0]  mdi [2];
    logic        mdv [2];
    logic        mov [2];
    logic [15:0] msc [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mh[i] = 0; mt[i] = 0; gl[i] = 0;
                mdi[i] = '0; mdv[i] = 1'b0; mov[i] = 1'b0; msc[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int  sz;
                bit  full;
                sz   = mt[i] - mh[i];
                full = (sz == 8);
                if (gl[i] == 0 && enable && sz > 0) begin
                    mdi[i] = mq[i][mh[i] % 1024];
                    mh[i]++;
                    msc[i] = msc[i] + 16'd1;
                    mdv[i] = 1'b1;
                    gl[i]  = (i == 0) ? 3 : 0;
                end else begin
                    mdv[i] = 1'b0;
                    if (gl[i] > 0) gl[i]--;
                end
                if (sensor_valid && !full) begin
                    mq[i][mt[i] % 1024] = sensor_data;
                    mt[i]++;
                end
                if (sensor_valid && full) mov[i] = 1'b1;
                else if (overflow_clr) mov[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                string t;
                t = (i == 0) ? "g3" : "g0";
                cmp({t, ".data_valid"},   32'(dv[i]), 32'(mdv[i]));
                cmp({t, ".data_input"},   32'(di[i]), 32'(mdi[i]));
                cmp({t, ".fifo_count"},   32'(fc[i]), 32'(mt[i] - mh[i]));
                cmp({t, ".sensor_ready"}, 32'(rdy[i]), 32'((mt[i] - mh[i]) != 8));
                cmp({t, ".overflow"},     32'(ov[i]), 32'(mov[i]));
                cmp({t, ".sample_count"}, 32'(sc[i]), 32'(msc[i]));
            end
        end
    end

    initial begin
        int          pc;
        int          pt [4];
        logic [7:0]  pv [4];
        logic [15:0] base;

        // Reset held with a sample offered: nothing may be accepted
        sensor_valid = 1'b1;
        sensor_data  = 8'h55;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cmp("rst.data_valid", 32'(dv[i]), 0);
            cmp("rst.data_input", 32'(di[i]), 0);
            cmp("rst.fifo_count", 32'(fc[i]), 0);
            cmp("rst.sensor_ready", 32'(rdy[i]), 1);
            cmp("rst.overflow", 32'(ov[i]), 0);
            cmp("rst.sample_count", 32'(sc[i]), 0);
        end
        sensor_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        cmp("rst.no_push", 32'(fc[0]), 0);

        // Single sample: push at edge k, pulse after edge k+1
        sensor_data  = 8'hAA;
        sensor_valid = 1'b1;
        @(negedge clk);
        sensor_valid = 1'b0;
        cmp("single.count_k", 32'(fc[0]), 1);
        cmp("single.valid_k", 32'(dv[0]), 0);
        @(negedge clk);
        cmp("single.valid", 32'(dv[0]), 1);
        cmp("single.data", 32'(di[0]), 32'h0AA);
        cmp("single.sample_count", 32'(sc[0]), 1);
        cmp("single.count_after", 32'(fc[0]), 0);
        @(negedge clk);
        cmp("single.pulse_end", 32'(dv[0]), 0);
        cmp("single.hold", 32'(di[0]), 32'h0AA);
        repeat (4) @(negedge clk);

        // Spacing with G=3
        pc = 0;
        for (int n = 0; n < 24; n++) begin
            sensor_valid = (n < 4);
            sensor_data  = 8'(8'h10 + n);
            @(negedge clk);
            if (dv[0]) begin
                if (pc < 4) begin
                    pt[pc] = n;
                    pv[pc] = di[0];
                end
                pc++;
            end
        end
        sensor_valid = 1'b0;
        cmp("spacing.pulses", 32'(pc), 4);
        cmp("spacing.latency", 32'(pt[0]), 1);
        for (int k = 0; k < 4; k++) cmp("spacing.order", 32'(pv[k]), 32'(8'h10 + k));
        for (int k = 1; k < 4; k++) cmp("spacing.gap", 32'(pt[k] - pt[k-1]), 4);

        // Fill to full with issue disabled, ninth sample dropped
        enable = 1'b0;
        for (int n = 0; n < 9; n++) begin
            sensor_valid = 1'b1;
            sensor_data  = 8'(8'h20 + n);
            @(negedge clk);
            if (n == 7) begin
                cmp("full.ready", 32'(rdy[1]), 0);
                cmp("full.count", 32'(fc[1]), 8);
                cmp("full.no_overflow_yet", 32'(ov[1]), 0);
            end
        end
        sensor_valid = 1'b0;
        cmp("full.overflow", 32'(ov[1]), 1);
        cmp("full.count_after_drop", 32'(fc[1]), 8);
        enable = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            cmp("drain.valid", 32'(dv[1]), 1);
            cmp("drain.data", 32'(di[1]), 32'(8'h20 + n));
        end
        @(negedge clk);
        cmp("drain.done", 32'(dv[1]), 0);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        cmp("ovf.clear", 32'(ov[1]), 0);
        repeat (40) @(negedge clk);

        // Continuous stream through the G=0 instance wraps both pointers
        base = sc[1];
        pc   = 0;
        for (int n = 0; n < 24; n++) begin
            sensor_valid = (n < 20);
            sensor_data  = 8'(n);
            @(negedge clk);
            if (dv[1]) begin
                cmp("wrap.order", 32'(di[1]), 32'(pc));
                pc++;
            end
        end
        sensor_valid = 1'b0;
        cmp("wrap.pulses", 32'(pc), 20);
        cmp("wrap.sample_count", 32'(16'(sc[1] - base)), 20);
        repeat (40) @(negedge clk);

        // Reset during a gap with three samples buffered
        for (int n = 0; n < 4; n++) begin
            sensor_valid = 1'b1;
            sensor_data  = 8'(8'h30 + n);
            @(negedge clk);
        end
        sensor_valid = 1'b0;
        cmp("midrst.count_before", 32'(fc[0]), 3);
        #2 reset = 1'b0;
        @(negedge clk);
        cmp("midrst.count", 32'(fc[0]), 0);
        cmp("midrst.valid", 32'(dv[0]), 0);
        cmp("midrst.ready", 32'(rdy[0]), 1);
        #2 reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            cmp("midrst.no_pulse", 32'(dv[0]), 0);
        end
        sensor_data  = 8'h5A;
        sensor_valid = 1'b1;
        @(negedge clk);
        sensor_valid = 1'b0;
        cmp("midrst.latency_k", 32'(dv[0]), 0);
        @(negedge clk);
        cmp("midrst.latency_k1", 32'(dv[0]), 1);
        cmp("midrst.data", 32'(di[0]), 32'h05A);
        repeat (6) @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sensor_valid = 1'($urandom_range(0, 1));
            sensor_data  = 8'($urandom);
            enable       = $urandom_range(0, 9) != 0;
            overflow_clr = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
